// File: rtl/fd_stage_reg.sv
`default_nettype none
// ============================================================================
// fd_stage_reg : F->D pipeline register with AdEL tagging, stall, flush, squash
// Revision     : 1.0
// ============================================================================
module fd_stage_reg #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        D_RegWE,
    input  logic        D_Eret,
    input  logic        D_IsBJ,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD,
    output logic        D_Valid
);

    logic        w_adel;
    logic [31:0] w_instr_chk;
    logic [4:0]  w_exc_chk;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  exc_q, exc_d;
    logic        bd_q, bd_d;
    logic        valid_q, valid_d;

    assign w_adel      = (F_PC[1:0] != 2'b00) || (F_PC < IM_LO) || (F_PC > IM_HI);
    assign w_instr_chk = w_adel ? 32'h0 : F_Instr;
    assign w_exc_chk   = w_adel ? EXC_ADEL : 5'd0;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
        if (Req) begin
            pc_d    = PC_HANDLER;
            instr_d = 32'h0;
            exc_d   = 5'd0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (!D_RegWE) begin
            // stalled: keep defaults (hold)
        end else if (D_Eret) begin
            // squashed slot keeps its PC but must never raise its own AdEL
            pc_d    = F_PC;
            instr_d = 32'h0;
            exc_d   = 5'd0;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else begin
            pc_d    = F_PC;
            instr_d = w_instr_chk;
            exc_d   = w_exc_chk;
            bd_d    = D_IsBJ;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'h0;
            exc_q   <= 5'd0;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
        end
    end

    assign D_PC      = pc_q;
    assign D_Instr   = instr_q;
    assign D_ExcCode = exc_q;
    assign D_BD      = bd_q;
    assign D_Valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fd_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_fd_stage_reg : directed self-checking bench for fd_stage_reg
// Revision        : 1.0
// ============================================================================
module tb_fd_stage_reg;

    logic        clk = 1'b0;
    logic        reset, Req, D_RegWE, D_Eret, D_IsBJ;
    logic [31:0] F_PC, F_Instr;
    logic [31:0] D_PC, D_Instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD, D_Valid;

    int checks = 0;
    int errors = 0;

    fd_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .D_RegWE   (D_RegWE),
        .D_Eret    (D_Eret),
        .D_IsBJ    (D_IsBJ),
        .F_PC      (F_PC),
        .F_Instr   (F_Instr),
        .D_PC      (D_PC),
        .D_Instr   (D_Instr),
        .D_ExcCode (D_ExcCode),
        .D_BD      (D_BD),
        .D_Valid   (D_Valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] exc, input logic bd, input logic valid);
        chk({tag, ".pc"},    D_PC, pc);
        chk({tag, ".instr"}, D_Instr, instr);
        chk({tag, ".exc"},   {27'd0, D_ExcCode}, {27'd0, exc});
        chk({tag, ".bd"},    {31'd0, D_BD}, {31'd0, bd});
        chk({tag, ".valid"}, {31'd0, D_Valid}, {31'd0, valid});
    endtask

    initial begin
        reset = 1'b1; Req = 1'b0; D_RegWE = 1'b1; D_Eret = 1'b0; D_IsBJ = 1'b0;
        F_PC = 32'h0000_5000; F_Instr = 32'h1234_5678;
        step();
        chk_all("reset", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

        reset = 1'b0; F_PC = 32'h3000; F_Instr = 32'h3C01_0001;
        step();
        chk_all("normal", 32'h3000, 32'h3C01_0001, 5'd0, 1'b0, 1'b1);

        F_PC = 32'h3002; F_Instr = 32'hFFFF_FFFF;
        step();
        chk_all("misalign", 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);
        F_PC = 32'h7000;
        step();
        chk_all("above_hi", 32'h7000, 32'h0, 5'd4, 1'b0, 1'b1);
        F_PC = 32'h2FFC;
        step();
        chk_all("below_lo", 32'h2FFC, 32'h0, 5'd4, 1'b0, 1'b1);
        F_PC = 32'h6FFC;
        step();
        chk_all("at_hi", 32'h6FFC, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1);

        F_PC = 32'h3004; F_Instr = 32'h2402_0005;
        step();
        chk_all("load", 32'h3004, 32'h2402_0005, 5'd0, 1'b0, 1'b1);
        D_RegWE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            F_PC = 32'h3008 + 32'(4 * i); F_Instr = 32'hA5A5_0000 + 32'(i); D_IsBJ = 1'b1;
            step();
            chk_all("stall", 32'h3004, 32'h2402_0005, 5'd0, 1'b0, 1'b1);
        end
        D_RegWE = 1'b1; D_IsBJ = 1'b0; F_PC = 32'h3008; F_Instr = 32'h1111_1111;
        step();
        chk_all("resume", 32'h3008, 32'h1111_1111, 5'd0, 1'b0, 1'b1);

        D_IsBJ = 1'b1; F_PC = 32'h3010; F_Instr = 32'h0000_0000;
        step();
        chk_all("bd_set", 32'h3010, 32'h0, 5'd0, 1'b1, 1'b1);
        D_IsBJ = 1'b0; F_PC = 32'h3014; F_Instr = 32'h2222_2222;
        step();
        chk_all("bd_clr", 32'h3014, 32'h2222_2222, 5'd0, 1'b0, 1'b1);

        D_RegWE = 1'b0; D_Eret = 1'b1; Req = 1'b1; F_PC = 32'h3018;
        step();
        chk_all("flush_prio", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);

        Req = 1'b0; D_RegWE = 1'b1; D_Eret = 1'b1; D_IsBJ = 1'b1;
        F_PC = 32'h3002; F_Instr = 32'h3333_3333;
        step();
        chk_all("eret_squash", 32'h3002, 32'h0, 5'd0, 1'b0, 1'b0);

        D_Eret = 1'b0; D_IsBJ = 1'b0; F_PC = 32'h3020; F_Instr = 32'h4444_4444;
        step();
        chk_all("pre_eret_stall", 32'h3020, 32'h4444_4444, 5'd0, 1'b0, 1'b1);
        D_RegWE = 1'b0; D_Eret = 1'b1; F_PC = 32'h3024; F_Instr = 32'h5555_5555;
        step();
        chk_all("eret_stall_hold", 32'h3020, 32'h4444_4444, 5'd0, 1'b0, 1'b1);
        D_RegWE = 1'b1;
        step();
        chk_all("eret_after_stall", 32'h3024, 32'h0, 5'd0, 1'b0, 1'b0);

        D_Eret = 1'b0; Req = 1'b1; F_PC = 32'h3028;
        step();
        chk_all("req_alone", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);

        reset = 1'b1; Req = 1'b1; D_Eret = 1'b1; D_IsBJ = 1'b1; F_PC = 32'h3030;
        step();
        chk_all("reset_mid", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b0; Req = 1'b0; D_Eret = 1'b0; D_IsBJ = 1'b1;
        F_PC = 32'h3034; F_Instr = 32'h6666_6666;
        step();
        chk_all("post_reset", 32'h3034, 32'h6666_6666, 5'd0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fd_stage_reg.md
# fd_stage_reg

Pipeline register between the fetch stage (PC register + instruction memory) and the decode stage of the five-stage MIPS core with precise exceptions. It samples the fetched PC and instruction every cycle. It tags fetch-stage exceptions (AdEL on illegal instruction address) and records whether the fetched instruction sits in a branch delay slot. It also implements the stall, exception-flush and ERET-squash rules that govern the F→D boundary.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset
- PC_HANDLER, 32'h0000_4180, PC value carried by a bubble injected on exception/interrupt flush
- IM_LO, 32'h0000_3000, lowest legal instruction address
- IM_HI, 32'h0000_6FFC, highest legal instruction address
- EXC_ADEL, 5'd4, ExcCode for instruction address error

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Req  in  1  exception/interrupt taken this cycle; flush F→D
- D_RegWE  in  1  0 = decode stalled, register holds
- D_Eret  in  1  ERET currently in D; squash fetched instruction
- D_IsBJ  in  1  instruction currently in D is a branch/jump
- F_PC  in  32  PC of instruction being fetched
- F_Instr  in  32  instruction word from instruction memory
- D_PC  out  32  registered PC
- D_Instr  out  32  registered instruction (0 = nop)
- D_ExcCode  out  5  registered fetch exception code (0 = none)
- D_BD  out  1  registered delay-slot flag
- D_Valid  out  1  1 = real instruction, 0 = bubble

## Operation
- Fetch exception check (combinational on F inputs): AdEL when F_PC[1:0] != 0, F_PC < IM_LO, or F_PC > IM_HI (unsigned compares). On AdEL, the captured instruction is forced to 32'h0 and the captured ExcCode is EXC_ADEL. Otherwise F_Instr is captured with ExcCode 0.
- Delay slot: captured BD = D_IsBJ, sampled in the same cycle.
- Update priority at each rising edge, highest first:
  1. reset: D_PC=PC_RESET, D_Instr=0, D_ExcCode=0, D_BD=0, D_Valid=0.
  2. Req=1, regardless of D_RegWE: D_PC=PC_HANDLER, D_Instr=0, D_ExcCode=0, D_BD=0, D_Valid=0.
  3. D_RegWE=0: hold all outputs.
  4. D_Eret=1: D_PC=F_PC, D_Instr=0, D_ExcCode=0, D_BD=0, D_Valid=0. The AdEL tag is dropped, because the squashed instruction must not raise.
  5. Otherwise, normal load: D_PC=F_PC, D_Instr=checked instruction, D_ExcCode=checked code, D_BD=D_IsBJ, D_Valid=1.
- Bubbles carry ExcCode 0 and BD 0, so they never raise exceptions or corrupt EPC/BD downstream.
- No internal state beyond the output registers. All outputs are registers; there is no combinational path from input to output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Stall: for k consecutive cycles with D_RegWE=0 (and no Req/reset), outputs are unchanged for k cycles. Loading resumes on the first edge with D_RegWE=1.
- Req during stall: flush wins, and the bubble appears after that edge.
- Req together with D_Eret: Req wins, so D_PC=PC_HANDLER.
- D_Eret during stall: hold. The squash happens on the first unstalled edge while D_Eret is still asserted.
- Reset mid-stream: takes effect at the next edge regardless of all other inputs. The first edge after reset deasserts performs a normal load.
- Boundary addresses: F_PC=IM_HI (0x6FFC) is legal. F_PC=0x7000, 0x2FFC, and any address with nonzero low bits raise AdEL.

## Test plan
- Reset then normal flow: reset 1 cycle; F_PC=0x3000, F_Instr=0x3C010001, D_IsBJ=0 -> after next edge D_PC=0x3000, D_Instr=0x3C010001, D_ExcCode=0, D_BD=0, D_Valid=1.
- Misaligned and out-of-range fetch: F_PC=0x3002, then 0x7000, then 0x6FFC, with F_Instr=0xFFFFFFFF -> D_Instr=0 and D_ExcCode=4 for the first two; D_Instr=0xFFFFFFFF and D_ExcCode=0 for 0x6FFC.
- Stall hold: load 0x3004/0x24020005, then D_RegWE=0 for 3 cycles while F inputs change -> outputs stay 0x3004/0x24020005 for all 3 cycles, then update on the 4th edge once D_RegWE=1.
- Delay slot: D_IsBJ=1 while F_PC=0x3010 -> D_BD=1, D_PC=0x3010. Next cycle D_IsBJ=0 -> D_BD=0.
- Flush priority: D_RegWE=0, D_Eret=1, Req=1 -> D_PC=0x4180, D_Instr=0, D_ExcCode=0, D_BD=0, D_Valid=0.
- ERET squash: D_Eret=1, D_RegWE=1, F_PC=0x3002 (misaligned) -> D_PC=0x3002, D_Instr=0, D_ExcCode=0, D_Valid=0.
